// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg
// Shared widths, FSM state codes and a small helper for the register-file dump
// engine. The CSUM state code only exists when REGFILE_DUMP_CSUM_EN is defined,
// so a default build carries no trace of the checksum path.
//   ADDR_W   : register index width
//   DATA_W   : register data width
//   NUM_REGS : number of architectural registers (index wraps at this count)
package regfile_dump_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // State encoding kept as plain constants so older tools and waveform scripts
  // that match on raw codes keep working.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SEND = 3'd2;
  localparam state_t ST_DONE = 3'd3;
`ifdef REGFILE_DUMP_CSUM_EN
  localparam state_t ST_CSUM = 3'd4;
`endif

  // NUM_REGS is a power of two, so the natural ADDR_W-bit rollover gives the
  // required 31 -> 0 wrap.
  function automatic logic [ADDR_W-1:0] next_index(input logic [ADDR_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump
// Walks a contiguous (possibly wrapping) range of register indices, reads each
// register through a combinational regfile read port and streams it out as a
// valid/ready beat. Each register is snapshotted in its LOAD cycle so the held
// beat is immune to later regfile writes.
// Optional feature: define REGFILE_DUMP_CSUM_EN to append one checksum beat
// (address 0, XOR of all register beats) after the register beats; in that
// build only the checksum beat carries o_dump_last.
// Ports:
//   i_clk          sole clock, rising edge
//   i_rst          synchronous active-high reset; aborts a dump without o_done
//   i_start        dump request, only looked at in IDLE
//   i_first_addr   first register index, latched on accepted start
//   i_last_addr    last register index, latched on accepted start
//   o_rf_addr      regfile read address (always the index register)
//   i_rf_data      regfile read data for o_rf_addr, same cycle
//   o_dump_valid   beat valid
//   i_dump_ready   consumer accepts beat
//   o_dump_addr    register index of the current beat
//   o_dump_data    register value of the current beat
//   o_dump_last    final beat marker
//   o_busy         high whenever not IDLE
//   o_done         one-cycle pulse after the final handshake
module regfile_dump
  import regfile_dump_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_last,
  output logic              o_busy,
  output logic              o_done
);

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] last_addr;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
`ifdef REGFILE_DUMP_CSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  // The first address only seeds the index, so it does not need its own
  // register; the last address is compared against the index on every beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      index      <= '0;
      last_addr  <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            index     <= i_first_addr;
            last_addr <= i_last_addr;
`ifdef REGFILE_DUMP_CSUM_EN
            checksum  <= '0;
`endif
            state     <= ST_LOAD;
          end
        end

        // Snapshot the register currently addressed by the index.
        ST_LOAD: begin
          dump_data  <= i_rf_data;
          dump_addr  <= index;
          dump_valid <= 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
          dump_last  <= 1'b0;
`else
          dump_last  <= (index == last_addr);
`endif
          state      <= ST_SEND;
        end

        // Hold the beat until the consumer takes it. The final register beat
        // is detected from the index rather than dump_last, because in the
        // checksum build register beats never carry dump_last.
        ST_SEND: begin
          if (i_dump_ready) begin
`ifdef REGFILE_DUMP_CSUM_EN
            checksum <= checksum ^ dump_data;
`endif
            if (index == last_addr) begin
`ifdef REGFILE_DUMP_CSUM_EN
              dump_valid <= 1'b1;
              dump_addr  <= '0;
              dump_data  <= checksum ^ dump_data;
              dump_last  <= 1'b1;
              state      <= ST_CSUM;
`else
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              state      <= ST_DONE;
`endif
            end else begin
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              index      <= next_index(index);
              state      <= ST_LOAD;
            end
          end
        end

`ifdef REGFILE_DUMP_CSUM_EN
        // The checksum beat is built directly on the last register handshake,
        // so here we only wait for it to be accepted.
        ST_CSUM: begin
          if (i_dump_ready) begin
            checksum   <= checksum ^ dump_data;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            state      <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register, so reset clears
  // them in the same edge that returns the FSM to IDLE.
  assign o_rf_addr    = index;
  assign o_dump_valid = dump_valid;
  assign o_dump_addr  = dump_addr;
  assign o_dump_data  = dump_data;
  assign o_dump_last  = dump_last;
  assign o_busy       = (state != ST_IDLE);
  assign o_done       = (state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump
// Drives regfile_dump against a behavioural register-file array and checks
// every beat against an expected beat list built from the range arithmetic.
module tb_regfile_dump;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [4:0]  i_first_addr;
  logic [4:0]  i_last_addr;
  logic [4:0]  o_rf_addr;
  logic [31:0] i_rf_data;
  logic        o_dump_valid;
  logic        i_dump_ready;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_last;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [0:31];
  int          errors = 0;
  int          checks = 0;

  regfile_dump dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_first_addr (i_first_addr),
    .i_last_addr  (i_last_addr),
    .o_rf_addr    (o_rf_addr),
    .i_rf_data    (i_rf_data),
    .o_dump_valid (o_dump_valid),
    .i_dump_ready (i_dump_ready),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_last  (o_dump_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // Combinational regfile read port.
  assign i_rf_data = rf[o_rf_addr];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One clock step: inputs already set are captured at the edge, then we move
  // 1 time unit past it so outputs are settled for sampling.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleCleared(input string tag);
    checkOutput({tag, " valid"}, 32'(o_dump_valid), 32'd0);
    checkOutput({tag, " busy"},  32'(o_busy),       32'd0);
    checkOutput({tag, " done"},  32'(o_done),       32'd0);
    checkOutput({tag, " last"},  32'(o_dump_last),  32'd0);
    checkOutput({tag, " addr"},  32'(o_dump_addr),  32'd0);
    checkOutput({tag, " data"},  o_dump_data,       32'd0);
    checkOutput({tag, " rfaddr"}, 32'(o_rf_addr),   32'd0);
  endtask

  // Runs one dump and checks every beat. stallBeat/stallLen hold ready low on
  // one beat and rewrite that register mid-stall; abortAt returns as soon as
  // beat number abortAt is on the bus, leaving the dump in flight.
  task automatic runDump(input string name, input logic [4:0] first,
                         input logic [4:0] last, input int stallBeat,
                         input int stallLen, input bit randReady,
                         input int abortAt);
    logic [4:0]  expAddr[$];
    logic [31:0] expData[$];
    logic        expLast[$];
    logic [31:0] xsum;
    int          n;
    int          total;
    int          beat;
    int          stall;
    int          doneSeen;
    int          cycles;
    bit          finished;
    bit          rdy;

    n    = ((int'(last) + 32 - int'(first)) % 32) + 1;
    xsum = 32'd0;
    for (int k = 0; k < n; k++) begin
      int a;
      a = (int'(first) + k) % 32;
      expAddr.push_back(5'(a));
      expData.push_back(rf[a]);
`ifdef REGFILE_DUMP_CSUM_EN
      expLast.push_back(1'b0);
`else
      expLast.push_back(k == n - 1);
`endif
      xsum = xsum ^ rf[a];
    end
`ifdef REGFILE_DUMP_CSUM_EN
    expAddr.push_back(5'd0);
    expData.push_back(xsum);
    expLast.push_back(1'b1);
`endif
    total    = expAddr.size();
    beat     = 0;
    stall    = 0;
    doneSeen = 0;
    cycles   = 0;
    finished = 1'b0;

    i_start      = 1'b1;
    i_first_addr = first;
    i_last_addr  = last;
    i_dump_ready = 1'b0;
    applyStimulus();
    checkOutput({name, " busy after start"}, 32'(o_busy), 32'd1);
    checkOutput({name, " rfaddr after start"}, 32'(o_rf_addr), 32'(first));

    while (!finished && cycles < 400) begin
      cycles++;
      if (abortAt >= 0 && beat == abortAt && o_dump_valid) begin
        i_start      = 1'b0;
        i_dump_ready = 1'b0;
        return;
      end
      if (o_done) begin
        doneSeen++;
        checkOutput({name, " beats before done"}, 32'(beat), 32'(total));
      end else if (doneSeen > 0) begin
        checkOutput({name, " busy after done"}, 32'(o_busy), 32'd0);
        finished = 1'b1;
      end
      if (o_dump_valid) begin
        if (beat < total) begin
          checkOutput({name, " addr"}, 32'(o_dump_addr), 32'(expAddr[beat]));
          checkOutput({name, " data"}, o_dump_data, expData[beat]);
          checkOutput({name, " last"}, 32'(o_dump_last), 32'(expLast[beat]));
        end else begin
          checkOutput({name, " extra beat"}, 32'(beat), 32'(total - 1));
        end
        if (beat == stallBeat && stall < stallLen) begin
          if (stall == 0) rf[expAddr[beat]] = ~rf[expAddr[beat]] ^ $urandom;
          stall++;
          rdy = 1'b0;
        end else begin
          rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rdy) beat++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      i_dump_ready = rdy;
      // Spurious starts with junk ranges while busy must be ignored.
      if (beat < total) begin
        i_start      = 1'($urandom_range(0, 1));
        i_first_addr = 5'($urandom);
        i_last_addr  = 5'($urandom);
      end else begin
        i_start = 1'b0;
      end
      applyStimulus();
    end
    i_start      = 1'b0;
    i_dump_ready = 1'b0;
    if (!finished) checkOutput({name, " timeout"}, 32'(cycles), 32'd0);
    checkOutput({name, " done pulses"}, 32'(doneSeen), 32'd1);
  endtask

  initial begin
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_first_addr = 5'd0;
    i_last_addr  = 5'd0;
    i_dump_ready = 1'b0;
    rf[0] = 32'h0000_0000;
    rf[1] = 32'hDEAD_BEEF;
    rf[2] = 32'hCAFE_BABE;
    for (int r = 3; r < 32; r++) rf[r] = $urandom;

    applyStimulus();
    applyStimulus();
    checkIdleCleared("reset");
    i_rst = 1'b0;
    applyStimulus();

    runDump("x1x2", 5'd1, 5'd2, -1, 0, 1'b0, -1);
    applyStimulus();
    runDump("single0", 5'd0, 5'd0, -1, 0, 1'b0, -1);
    runDump("wrap30to1", 5'd30, 5'd1, -1, 0, 1'b1, -1);
    runDump("stall", 5'd1, 5'd3, 1, 5, 1'b0, -1);
    runDump("after stall x2", 5'd2, 5'd2, -1, 0, 1'b0, -1);

    runDump("abort", 5'd0, 5'd31, -1, 0, 1'b0, 2);
    i_rst   = 1'b1;
    i_start = 1'b1;
    applyStimulus();
    checkIdleCleared("abort reset");
    i_rst   = 1'b0;
    i_start = 1'b0;
    applyStimulus();
    checkOutput("abort no done", 32'(o_done), 32'd0);
    checkOutput("abort stays idle", 32'(o_busy), 32'd0);
    runDump("full0to31", 5'd0, 5'd31, -1, 0, 1'b1, -1);

    for (int t = 0; t < 4; t++) begin
      runDump("random", 5'($urandom), 5'($urandom), -1, 0, 1'b1, -1);
      if (t == 1) rf[$urandom_range(1, 31)] = $urandom;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
